joy_input_conditioner: RTL and testbench

Conditions raw player controls for the arcade core. It takes the merged joystick and keyboard button vectors for two players, synchronises them into `clk_sys`, debounces them and applies the screen-rotation remap. It turns each coin input into a single fixed-width pulse and registers the results, which drive the core's `joy_pcfrldu` / `joy_pcfrldu2` inputs. It sits between the DB9/DB15/USB/PS2 input merge and the game core.

---
 rtl/joy_input_conditioner.sv | 260 ++++++++++++++++++++++++++
 tb/tb_joy_input_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_input_conditioner.sv
// joy_input_conditioner
//
// Conditions the merged player controls before they reach the game core.
// Each raw button goes through a 2-flop synchroniser into clk_sys and then a
// per-bit debouncer. The direction bits are remapped for horizontal screens,
// and each coin input becomes one fixed-width pulse. All outputs are registered.
//
// Ports
//   clk_sys       in   core clock (only clock of the block)
//   reset_n       in   asynchronous active-low reset
//   joy_raw_1     in 7 P1 {coin,start,fire,right,left,down,up}, async, active-high
//   joy_raw_2     in 7 P2, same layout
//   no_rotate     in   1 = horizontal-screen direction remap, applied undebounced
//   joy_pcfrldu   out 7 P1 conditioned controls, same layout
//   joy_pcfrldu2  out 7 P2 conditioned controls
//   osd_combo     out   debounced P1 start AND P1 coin (before coin shaping)

// ---------------------------------------------------------------------------
// joy_debounce: WIDTH independent debouncers, one stable value + counter each.
//   clk_i / rst_ni  clock, async active-low reset
//   din_i           synchronised inputs
//   dout_o          debounced (stable) values
// ---------------------------------------------------------------------------
module joy_debounce #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned      CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // The counter holds the number of mismatching cycles already seen; the
  // CYCLES-th consecutive mismatch toggles the stable value. Any cycle that
  // matches the stable value clears the count, so the counter never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '{default: '0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din_i[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout_o = stable_q;

endmodule

// ---------------------------------------------------------------------------
// joy_coin_shaper: turns a debounced coin level into one fixed-width pulse,
// then insists on a qualified low period before accepting another coin.
//   clk_i / rst_ni  clock, async active-low reset
//   coin_i          debounced coin level
//   pulse_o         pulse value for the next output register load (combinational)
// ---------------------------------------------------------------------------
module joy_coin_shaper #(
  parameter int unsigned PULSE_CYCLES = 10,
  parameter int unsigned GUARD_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic coin_i,
  output logic pulse_o
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES
                                                                  : GUARD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT_REL,
    ST_GUARD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_prev_q;

  // The pulse is asserted combinationally on the rising edge in IDLE so that
  // the registered coin output lines up with the other debounced bits. The
  // counter is loaded with PULSE_CYCLES-1 because that first cycle already
  // counts as part of the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_i && !coin_prev_q) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          pulse_o = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_REL;
        end else begin
          pulse_o = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!coin_i) begin
          state_d = ST_GUARD;
          cnt_d   = CNT_W'(GUARD_CYCLES);
        end
      end
      ST_GUARD: begin
        if (coin_i) begin
          cnt_d = CNT_W'(GUARD_CYCLES);
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_prev_q <= coin_i;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module joy_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 12000,
  parameter int unsigned COIN_PULSE_CYCLES = 1200000,
  parameter int unsigned COIN_GUARD_CYCLES = 600000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [6:0] joy_raw_1,
  input  logic [6:0] joy_raw_2,
  input  logic       no_rotate,
  output logic [6:0] joy_pcfrldu,
  output logic [6:0] joy_pcfrldu2,
  output logic       osd_combo
);

  logic [13:0] sync1_q, sync2_q;
  logic [13:0] db;
  logic [6:0]  db1, db2;
  logic        coin1_pulse, coin2_pulse;
  logic [6:0]  joy1_q, joy1_d, joy2_q, joy2_d;
  logic        osd_q, osd_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {joy_raw_2, joy_raw_1};
      sync2_q <= sync1_q;
    end
  end

  joy_debounce #(
    .WIDTH  (14),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .din_i  (sync2_q),
    .dout_o (db)
  );

  assign db1 = db[6:0];
  assign db2 = db[13:7];

  joy_coin_shaper #(
    .PULSE_CYCLES (COIN_PULSE_CYCLES),
    .GUARD_CYCLES (COIN_GUARD_CYCLES)
  ) u_coin_p1 (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .coin_i  (db1[6]),
    .pulse_o (coin1_pulse)
  );

  joy_coin_shaper #(
    .PULSE_CYCLES (COIN_PULSE_CYCLES),
    .GUARD_CYCLES (COIN_GUARD_CYCLES)
  ) u_coin_p2 (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .coin_i  (db2[6]),
    .pulse_o (coin2_pulse)
  );

  // Direction nibble {right,left,down,up}. Horizontal remap:
  // up<=left, down<=right, left<=down, right<=up.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input logic nr);
    return nr ? {d[0], d[1], d[3], d[2]} : d;
  endfunction

  always_comb begin
    joy1_d = {coin1_pulse, db1[5:4], rotate_dirs(db1[3:0], no_rotate)};
    joy2_d = {coin2_pulse, db2[5:4], rotate_dirs(db2[3:0], no_rotate)};
    osd_d  = db1[5] & db1[6];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy1_q <= '0;
      joy2_q <= '0;
      osd_q  <= 1'b0;
    end else begin
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
      osd_q  <= osd_d;
    end
  end

  assign joy_pcfrldu  = joy1_q;
  assign joy_pcfrldu2 = joy2_q;
  assign osd_combo    = osd_q;

endmodule

// File: tb/tb_joy_input_conditioner.sv
`timescale 1ns/1ps
module tb_joy_input_conditioner;

  localparam int MAXC = 80;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [6:0] joy_raw_1, joy_raw_2;
  logic       no_rotate;
  logic [6:0] joy_pcfrldu, joy_pcfrldu2;
  logic       osd_combo;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle stimulus (applied in cycle k, i.e. just after edge k).
  logic [6:0] s1  [0:MAXC];
  logic [6:0] s2  [0:MAXC];
  logic       snr [0:MAXC];
  logic       sr  [0:MAXC];
  // Outputs observed just after edge k, and shortly after cycle-k stimulus.
  logic [6:0] t1 [0:MAXC];
  logic [6:0] t2 [0:MAXC];
  logic       to [0:MAXC];
  logic [6:0] m1 [0:MAXC];
  logic [6:0] m2 [0:MAXC];
  logic       mo [0:MAXC];

  joy_input_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .COIN_PULSE_CYCLES (10),
    .COIN_GUARD_CYCLES (3)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .joy_raw_1    (joy_raw_1),
    .joy_raw_2    (joy_raw_2),
    .no_rotate    (no_rotate),
    .joy_pcfrldu  (joy_pcfrldu),
    .joy_pcfrldu2 (joy_pcfrldu2),
    .osd_combo    (osd_combo)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k <= MAXC; k++) begin
      s1[k]  = '0;
      s2[k]  = '0;
      snr[k] = 1'b0;
      sr[k]  = 1'b1;
    end
  endtask

  // Resets the DUT, releases reset in cycle 0 and plays n+1 cycles of stimulus.
  task automatic run_scen(input int n);
    reset_n   = 1'b0;
    joy_raw_1 = '0;
    joy_raw_2 = '0;
    no_rotate = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk_sys);
        #1;
      end
      t1[k] = joy_pcfrldu;
      t2[k] = joy_pcfrldu2;
      to[k] = osd_combo;
      joy_raw_1 = s1[k];
      joy_raw_2 = s2[k];
      no_rotate = snr[k];
      reset_n   = sr[k];
      #1;
      m1[k] = joy_pcfrldu;
      m2[k] = joy_pcfrldu2;
      mo[k] = osd_combo;
    end
  endtask

  function automatic int cnt_bit1(input int b, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (t1[k][b]) c++;
    return c;
  endfunction

  function automatic int cnt_bit2(input int b, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (t2[k][b]) c++;
    return c;
  endfunction

  function automatic int cnt_nz2(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (t2[k] != 7'h00) c++;
    return c;
  endfunction

  function automatic int cnt_osd(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (to[k]) c++;
    return c;
  endfunction

  initial begin
    reset_n   = 1'b0;
    joy_raw_1 = '0;
    joy_raw_2 = '0;
    no_rotate = 1'b0;

    // Up press/release on P1; short and minimal fire pulses on P2.
    clear_stim();
    for (int k = 0; k <= 19; k++) s1[k] = 7'h01;
    for (int k = 2; k <= 4; k++)  s2[k] = 7'h10;
    for (int k = 30; k <= 33; k++) s2[k] = 7'h10;
    run_scen(45);
    check_eq("rst_p1", t1[0], 7'h00);
    check_eq("rst_p2", t2[0], 7'h00);
    check_eq("rst_osd", to[0], 1'b0);
    check_eq("up_e6", t1[6], 7'h00);
    check_eq("up_e7", t1[7], 7'h01);
    check_eq("up_e26", t1[26], 7'h01);
    check_eq("up_e27", t1[27], 7'h00);
    check_eq("glitch3_quiet", cnt_nz2(0, 36), 0);
    check_eq("pulse4_e36", t2[36], 7'h00);
    check_eq("pulse4_e37", t2[37], 7'h10);
    check_eq("pulse4_e40", t2[40], 7'h10);
    check_eq("pulse4_e41", t2[41], 7'h00);
    check_eq("pulse4_len", cnt_bit2(4, 0, 45), 4);

    // Coin held 50 cycles on both players simultaneously.
    clear_stim();
    for (int k = 0; k <= 49; k++) begin
      s1[k] = 7'h40;
      s2[k] = 7'h40;
    end
    run_scen(70);
    check_eq("coin_e6", t1[6], 7'h00);
    check_eq("coin_e7", t1[7], 7'h40);
    check_eq("coin_e16", t1[16], 7'h40);
    check_eq("coin_e17", t1[17], 7'h00);
    check_eq("coin_len", cnt_bit1(6, 0, 70), 10);
    check_eq("coin2_e7", t2[7], 7'h40);
    check_eq("coin2_len", cnt_bit2(6, 0, 70), 10);
    check_eq("coin_osd_quiet", cnt_osd(0, 70), 0);

    // Guard: shortest qualified release then re-press gives no pulse;
    // a long release lets the next press through.
    clear_stim();
    for (int k = 0; k <= 14; k++)  s1[k] = 7'h40;
    for (int k = 19; k <= 34; k++) s1[k] = 7'h40;
    for (int k = 50; k <= 70; k++) s1[k] = 7'h40;
    run_scen(75);
    check_eq("guard_first_e7", t1[7], 7'h40);
    check_eq("guard_first_e17", t1[17], 7'h00);
    check_eq("guard_nopulse", cnt_bit1(6, 17, 56), 0);
    check_eq("guard_new_e57", t1[57], 7'h40);
    check_eq("guard_new_e66", t1[66], 7'h40);
    check_eq("guard_new_e67", t1[67], 7'h00);
    check_eq("guard_total", cnt_bit1(6, 0, 75), 20);

    // Rotation remap, undebounced no_rotate change, osd combo.
    clear_stim();
    for (int k = 0; k <= 34; k++) snr[k] = 1'b1;
    for (int k = 0; k <= 9; k++)   s1[k] = 7'h04;
    for (int k = 10; k <= 19; k++) s1[k] = 7'h08;
    for (int k = 20; k <= 29; k++) s1[k] = 7'h10;
    for (int k = 30; k <= 45; k++) s1[k] = 7'h60;
    for (int k = 0; k <= 45; k++)  s2[k] = 7'h04;
    run_scen(45);
    check_eq("rot_left_e7", t1[7], 7'h01);
    check_eq("rot_left_e16", t1[16], 7'h01);
    check_eq("rot_right_e17", t1[17], 7'h02);
    check_eq("rot_right_e26", t1[26], 7'h02);
    check_eq("rot_fire_e27", t1[27], 7'h10);
    check_eq("rot_fire_e36", t1[36], 7'h10);
    check_eq("startcoin_e37", t1[37], 7'h60);
    check_eq("osd_e36", to[36], 1'b0);
    check_eq("osd_e37", to[37], 1'b1);
    check_eq("osd_e40", to[40], 1'b1);
    check_eq("nr_p2_e35", t2[35], 7'h01);
    check_eq("nr_p2_e36", t2[36], 7'h04);

    // Reset in the middle of a coin pulse with the coin held throughout.
    clear_stim();
    for (int k = 0; k <= 45; k++)  s1[k] = 7'h40;
    for (int k = 11; k <= 14; k++) sr[k] = 1'b0;
    run_scen(45);
    check_eq("rstmid_e11", t1[11], 7'h40);
    check_eq("rstmid_now_p1", m1[11], 7'h00);
    check_eq("rstmid_now_p2", m2[11], 7'h00);
    check_eq("rstmid_now_osd", mo[11], 1'b0);
    check_eq("rstmid_e15", t1[15], 7'h00);
    check_eq("rstmid_e21", t1[21], 7'h00);
    check_eq("rstmid_e22", t1[22], 7'h40);
    check_eq("rstmid_e31", t1[31], 7'h40);
    check_eq("rstmid_e32", t1[32], 7'h00);
    check_eq("rstmid_len", cnt_bit1(6, 16, 45), 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
